tx_scrambler_64b66b: RTL

Transmit-path 64b/66b scrambler sitting directly downstream of the PCS encoder: it consumes each 66-bit coded block and scrambles the 64-bit payload with the self-synchronous polynomial x^58 + x^39 + 1 (IEEE 802.3 Cl. 49/82). The 2-bit sync header passes through untouched. The block adds one register stage and counts blocks arriving with an invalid sync header. Its output feeds block distribution / alignment-marker insertion.

---
 rtl/tx_scrambler_64b66b.sv | 81 ++++++++
 1 files changed

// File: rtl/tx_scrambler_64b66b.sv
// Transmit 64b/66b payload scrambler (x^58 + x^39 + 1) with one register stage
// and a saturating count of blocks carrying an invalid sync header.
module tx_scrambler_64b66b #(
  parameter int unsigned LEN_CODED_BLOCK = 66,
  parameter int unsigned LEN_SCR_STATE   = 58,
  parameter logic [LEN_SCR_STATE-1:0] SCR_SEED = 58'h3FF_FFFF_FFFF_FFFF,
  parameter int unsigned LEN_ERR_CNT     = 16
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic                       i_enable,
  input  logic                       i_valid,
  input  logic                       i_bypass,
  input  logic                       i_clear_err,
  input  logic [LEN_CODED_BLOCK-1:0] i_tx_coded,
  output logic [LEN_CODED_BLOCK-1:0] o_tx_scrambled,
  output logic                       o_valid,
  output logic [LEN_ERR_CNT-1:0]     o_err_count
);

  localparam int unsigned LEN_PAYLOAD = LEN_CODED_BLOCK - 2;

  logic [LEN_SCR_STATE-1:0] state_q;
  logic [LEN_SCR_STATE-1:0] state_next;
  logic [LEN_PAYLOAD-1:0]   scr_payload;
  logic [1:0]               sync_header;
  logic                     accept;
  logic                     bad_header;
  logic                     fb;

  assign sync_header = i_tx_coded[LEN_CODED_BLOCK-1 -: 2];
  assign accept      = i_enable && i_valid;
  assign bad_header  = (sync_header == 2'b00) || (sync_header == 2'b11);

  // Bit-serial recurrence unrolled MSB-first; the state after the last step is
  // exactly the most recent LEN_SCR_STATE scrambled bits.
  always_comb begin
    state_next  = state_q;
    scr_payload = '0;
    fb          = 1'b0;
    for (int unsigned i = 0; i < LEN_PAYLOAD; i++) begin
      fb = i_tx_coded[LEN_PAYLOAD-1-i] ^ state_next[38] ^ state_next[LEN_SCR_STATE-1];
      scr_payload[LEN_PAYLOAD-1-i] = fb;
      state_next = {state_next[LEN_SCR_STATE-2:0], fb};
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= SCR_SEED;
    end else if (accept && !i_bypass) begin
      state_q <= state_next;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      o_tx_scrambled <= '0;
      o_valid        <= 1'b0;
    end else if (i_enable) begin
      o_valid <= i_valid;
      if (i_valid) begin
        o_tx_scrambled <= {sync_header, (i_bypass ? i_tx_coded[LEN_PAYLOAD-1:0] : scr_payload)};
      end
    end
  end

  // Clear has priority over a coincident header error.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      o_err_count <= '0;
    end else if (i_enable) begin
      if (i_clear_err) begin
        o_err_count <= '0;
      end else if (accept && bad_header && (o_err_count != '1)) begin
        o_err_count <= o_err_count + 1'b1;
      end
    end
  end

endmodule
